multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 329 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control unit for a classic multicycle MIPS-style datapath. It is a Moore
// FSM whose datapath controls are registered and aligned with State. Three
// strobes have to react to inputs in the same cycle, so they are qualified
// combinationally: the FETCH write strobes by mem_ready, and the BRANCH
// PC write by Zero.
//
// A wait counter tracks consecutive mem_ready=0 cycles in the memory wait
// states (FETCH, MEM_READ, MEM_WRITE). When the count reaches MEM_WAIT_MAX,
// mem_timeout is set and stays set until reset. The following cycle is a
// "blank" cycle: all controls are 0 and the FSM is forced back to FETCH.
//
// Optional feature: define JUMP_LINK_EN to enable the JAL and JR states.
// Without it, OP=0x03 decodes as illegal and Function=0x08 is an ordinary
// R-type instruction.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               synchronous, active-high
//   OP, Function        opcode / funct fields of the instruction register
//   Zero                ALU zero flag (used in BRANCH)
//   mem_ready           memory completes the current access this cycle
//   PCWrite .. ALUSrcA  1-bit datapath strobes / selects
//   ALUSrcB, PCSource   2-bit selects
//   ALUOp               3-bit ALU operation
//   State               current state code
//   illegal_op          one-cycle pulse after decoding an unknown opcode
//   mem_timeout         sticky memory-timeout flag
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Function,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [3:0] State,
  output logic       illegal_op,
  output logic       mem_timeout
);

`ifdef JUMP_LINK_EN
  localparam logic LINK_EN = 1'b1;
`else
  localparam logic LINK_EN = 1'b0;
`endif

  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_WAIT_MAX);

  localparam logic [2:0] ALU_SUB   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13
  } state_t;

  // Registered control word. fetch_strobe, beq and bne are not outputs on
  // their own; they qualify PCWrite/IRWrite with same-cycle inputs.
  typedef struct packed {
    logic       fetch_strobe;
    logic       pc_write;
    logic       beq;
    logic       bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic            mem_timeout_reg, mem_timeout_next;
  logic            illegal_op_reg, illegal_op_next;
  ctrl_t           ctrl_reg, ctrl_next;
  logic            wait_state;
  logic            timeout_cycle;
  logic            blank_next;
  logic            jr_decode;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ORI:  imm_alu_op = ALU_OR;
      OP_LUI:  imm_alu_op = ALU_LUI;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

  // Control word presented while the FSM sits in state s.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch_strobe = 1'b1;
        c.mem_read     = 1'b1;
        c.alu_src_b    = 2'b01;
        c.alu_op       = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_source = 2'b01;
        c.beq       = (op == OP_BEQ);
        c.bne       = (op == OP_BNE);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = imm_alu_op(op);
      end
      S_I_WB: begin
        c.reg_write = 1'b1;
      end
`ifdef JUMP_LINK_EN
      S_JAL: begin
        // Link writes PC into $ra; RegDst=1 is the select override for it.
        c.reg_write = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.reg_dst   = 1'b1;
      end
      S_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b11;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_state    = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                         (state_reg == S_MEM_WRITE);
  // The counter only reaches CNT_MAX in a wait state, so this marks the
  // blank cycle that follows the last tolerated wait cycle.
  assign timeout_cycle = wait_state && (wait_cnt_reg == CNT_MAX);
  assign jr_decode     = LINK_EN && (Function == FN_JR);

  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = '0;
    mem_timeout_next = mem_timeout_reg;
    illegal_op_next  = 1'b0;

    if (timeout_cycle) begin
      state_next = S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) state_next = S_DECODE;
          else           wait_cnt_next = wait_cnt_reg + 1'b1;
        end
        S_DECODE: begin
          case (OP)
            OP_LW, OP_SW:            state_next = S_MEM_ADDR;
            OP_RTYPE:                state_next = jr_decode ? S_JR : S_R_EXEC;
            OP_BEQ, OP_BNE:          state_next = S_BRANCH;
            OP_J:                    state_next = S_JUMP;
            OP_ADDI, OP_ORI, OP_LUI: state_next = S_I_EXEC;
            OP_JAL: begin
              if (LINK_EN) begin
                state_next = S_JAL;
              end else begin
                state_next      = S_FETCH;
                illegal_op_next = 1'b1;
              end
            end
            default: begin
              state_next      = S_FETCH;
              illegal_op_next = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          if (OP == OP_LW)      state_next = S_MEM_READ;
          else if (OP == OP_SW) state_next = S_MEM_WRITE;
          else                  state_next = S_FETCH;
        end
        S_MEM_READ: begin
          if (mem_ready) state_next = S_MEM_WB;
          else           wait_cnt_next = wait_cnt_reg + 1'b1;
        end
        S_MEM_WRITE: begin
          if (mem_ready) state_next = S_FETCH;
          else           wait_cnt_next = wait_cnt_reg + 1'b1;
        end
        S_R_EXEC: state_next = S_R_WB;
        S_I_EXEC: state_next = S_I_WB;
        default:  state_next = S_FETCH;
      endcase
    end

    // Reaching the limit blanks the next cycle's controls and latches the
    // sticky flag.
    blank_next = (wait_cnt_next == CNT_MAX);
    if (blank_next) mem_timeout_next = 1'b1;

    if (blank_next) begin
      ctrl_next = '0;
    end else begin
      ctrl_next = ctrl_for(state_next, OP);
      // I_WB keeps the immediate ALU operation chosen in I_EXEC.
      if (state_next == S_I_WB) ctrl_next.alu_op = ctrl_reg.alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_FETCH;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
      illegal_op_reg  <= 1'b0;
      ctrl_reg        <= ctrl_for(S_FETCH, OP);
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
      illegal_op_reg  <= illegal_op_next;
      ctrl_reg        <= ctrl_next;
    end
  end

  // Strobes are gated by reset so nothing is written while reset is held,
  // even in the cycle before the reset edge is sampled.
  assign PCWrite  = ~reset & (ctrl_reg.pc_write |
                              (ctrl_reg.fetch_strobe & mem_ready) |
                              (ctrl_reg.beq & Zero) |
                              (ctrl_reg.bne & ~Zero));
  assign IRWrite  = ~reset & ctrl_reg.fetch_strobe & mem_ready;
  assign MemRead  = ~reset & ctrl_reg.mem_read;
  assign MemWrite = ~reset & ctrl_reg.mem_write;
  assign RegWrite = ~reset & ctrl_reg.reg_write;

  assign IorD        = ctrl_reg.iord;
  assign MemtoReg    = ctrl_reg.mem_to_reg;
  assign RegDst      = ctrl_reg.reg_dst;
  assign ALUSrcA     = ctrl_reg.alu_src_a;
  assign ALUSrcB     = ctrl_reg.alu_src_b;
  assign PCSource    = ctrl_reg.pc_source;
  assign ALUOp       = ctrl_reg.alu_op;
  assign State       = state_reg;
  assign illegal_op  = illegal_op_reg;
  assign mem_timeout = mem_timeout_reg;

endmodule
